// File: rtl/hex_counter_pkg.sv
// hex_counter_pkg: shared constants for the hex digit counter.
// Speed encoding, digit width and the divider period lookup.
// Optional feature macro used elsewhere: HEX_COUNTER_LOAD_EN.
package hex_counter_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [1:0] SPD_FULL    = 2'b00;  // advance every enabled cycle
  localparam logic [1:0] SPD_1HZ     = 2'b01;  // period CLK_HZ
  localparam logic [1:0] SPD_HALF    = 2'b10;  // period 2*CLK_HZ
  localparam logic [1:0] SPD_QUARTER = 2'b11;  // period 4*CLK_HZ

  // Divider period in clock cycles for a given speed code.
  function automatic int unsigned period_cycles(input logic [1:0] spd,
                                                input int unsigned clk_hz);
    case (spd)
      SPD_FULL: return 1;
      SPD_1HZ:  return clk_hz;
      SPD_HALF: return 2 * clk_hz;
      default:  return 4 * clk_hz;
    endcase
  endfunction

endpackage

// File: rtl/hex_counter_if.sv
// hex_counter_if: control and result signals of the hex digit counter.
// load/load_val exist only when HEX_COUNTER_LOAD_EN is defined.
interface hex_counter_if;
  import hex_counter_pkg::*;

  logic               enable;
  logic [1:0]         speed;
`ifdef HEX_COUNTER_LOAD_EN
  logic               load;
  logic [DIGIT_W-1:0] load_val;
`endif
  logic [DIGIT_W-1:0] digit;
  logic               tick;
  logic               wrap;

`ifdef HEX_COUNTER_LOAD_EN
  modport master (output enable, speed, load, load_val,
                  input  digit, tick, wrap);
  modport slave  (input  enable, speed, load, load_val,
                  output digit, tick, wrap);
`else
  modport master (output enable, speed,
                  input  digit, tick, wrap);
  modport slave  (input  enable, speed,
                  output digit, tick, wrap);
`endif

endinterface

// File: rtl/hex_counter_rate_divider.sv
// rate_divider: period selection, divider counter and advance strobe.
// The counter runs upward from 0 to P-1; the remaining count (P-1 - cnt_q)
// behaves exactly like a divider loaded with P-1 and counting down to 0.
// A speed change or an external reload restarts the full period.
module rate_divider
  import hex_counter_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int DIV_W  = 28
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       enable,
  input  logic [1:0] speed,
  input  logic       reload,
  output logic       adv
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] last;
  logic [1:0]       spd_q;
  logic             spd_chg;
  logic             at_end;

  // Terminal count P-1 for the currently selected speed.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    last = '0;
    last = DIV_W'(period_cycles(speed, CLK_HZ) - 1);
  end

  assign spd_chg = (speed != spd_q);
  assign at_end  = (cnt_q == last);
  assign adv     = enable && at_end && !spd_chg && !reload;

  // Divider count and speed history; restart on reload or speed change.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      // NOTE: history tracks the live speed during reset so release never looks like a speed change.
      spd_q <= speed;
    end else begin
      spd_q <= speed;
      if (reload || spd_chg) begin
        cnt_q <= '0;
      end else if (enable) begin
        cnt_q <= at_end ? '0 : cnt_q + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/hex_counter.sv
// hex_counter: 4-bit hex digit that advances at a selectable rate.
// Owns digit, tick and wrap; the divider lives in rate_divider.
// Optional parallel load is enabled with HEX_COUNTER_LOAD_EN.
module hex_counter
  import hex_counter_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int DIV_W  = 28
) (
  input  logic         clock,
  input  logic         resetn,
  hex_counter_if.slave bus
);

  logic [DIGIT_W-1:0] digit_q;
  logic               tick_q;
  logic               wrap_q;
  logic               adv;
  logic               ld;
  logic [DIGIT_W-1:0] ld_val;

`ifdef HEX_COUNTER_LOAD_EN
  assign ld     = bus.load;
  assign ld_val = bus.load_val;
`else
  assign ld     = 1'b0;
  assign ld_val = '0;
`endif

  rate_divider #(
    .CLK_HZ (CLK_HZ),
    .DIV_W  (DIV_W)
  ) u_div (
    .clock  (clock),
    .resetn (resetn),
    .enable (bus.enable),
    .speed  (bus.speed),
    .reload (ld),
    .adv    (adv)
  );

  // Digit register with registered tick/wrap pulses; load wins over advance.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      digit_q <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (ld) begin
      digit_q <= ld_val;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (adv) begin
      digit_q <= digit_q + DIGIT_W'(1);
      tick_q  <= 1'b1;
      wrap_q  <= (digit_q == '1);
    end else begin
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end
  end

  assign bus.digit = digit_q;
  assign bus.tick  = tick_q;
  assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_hex_counter.sv
// tb_hex_counter: directed scenarios plus randomized stimulus against a
// cycle-level reference model of the hex counter (CLK_HZ=4).
// Load scenarios run only when HEX_COUNTER_LOAD_EN is defined.
module tb_hex_counter;
  import hex_counter_pkg::*;

  localparam int CLK_HZ = 4;
  localparam int DIV_W  = 8;

  logic clk    = 1'b0;
  logic resetn = 1'b1;

  hex_counter_if bus();

  hex_counter #(
    .CLK_HZ (CLK_HZ),
    .DIV_W  (DIV_W)
  ) dut (
    .clock  (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;

  // Reference model: cycles remaining before the next advance, plus outputs.
  int         m_digit;
  int         m_rem;
  logic [1:0] m_prev;
  logic       m_tick;
  logic       m_wrap;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int period(input logic [1:0] s);
    case (s)
      2'b00:   return 1;
      2'b01:   return CLK_HZ;
      2'b10:   return 2 * CLK_HZ;
      default: return 4 * CLK_HZ;
    endcase
  endfunction

  task automatic drive(input logic en, input logic [1:0] spd,
                       input logic ld, input logic [3:0] lv);
    bus.enable = en;
    bus.speed  = spd;
`ifdef HEX_COUNTER_LOAD_EN
    bus.load     = ld;
    bus.load_val = lv;
`else
    if (ld || (lv != 4'h0)) $display("note: load requested without load feature");
`endif
  endtask

  // One clock cycle: drive inputs, advance the model, compare after the edge.
  task automatic step(input logic en, input logic [1:0] spd,
                      input logic ld = 1'b0, input logic [3:0] lv = 4'h0);
    drive(en, spd, ld, lv);
    if (ld) begin
      m_digit = int'(lv);
      m_tick  = 1'b0;
      m_wrap  = 1'b0;
      m_rem   = period(spd) - 1;
    end else if (spd != m_prev) begin
      m_tick = 1'b0;
      m_wrap = 1'b0;
      m_rem  = period(spd) - 1;
    end else if (en && m_rem == 0) begin
      m_digit = (m_digit + 1) % 16;
      m_tick  = 1'b1;
      m_wrap  = (m_digit == 0);
      m_rem   = period(spd) - 1;
    end else begin
      m_tick = 1'b0;
      m_wrap = 1'b0;
      if (en) m_rem--;
    end
    m_prev = spd;
    @(posedge clk);
    #1;
    check("digit", 32'(bus.digit), 32'(m_digit));
    check("tick",  32'(bus.tick),  32'(m_tick));
    check("wrap",  32'(bus.wrap),  32'(m_wrap));
  endtask

  // Asynchronous reset between edges, checked before any edge, then released.
  task automatic do_reset(input logic [1:0] spd);
    drive(1'b1, spd, 1'b0, 4'h0);
    resetn = 1'b0;
    #1;
    check("rst_async_digit", 32'(bus.digit), 32'd0);
    check("rst_async_tick",  32'(bus.tick),  32'd0);
    check("rst_async_wrap",  32'(bus.wrap),  32'd0);
    @(posedge clk);
    #1;
    check("rst_hold_digit", 32'(bus.digit), 32'd0);
    resetn  = 1'b1;
    m_digit = 0;
    m_tick  = 1'b0;
    m_wrap  = 1'b0;
    m_prev  = spd;
    m_rem   = period(spd) - 1;
  endtask

  initial begin
    int first_tick;
    int ticks;
    int wraps;
    int enabled;
    int gap;
    logic       got;
    logic       en;
    logic [1:0] spd;
    logic       ld;
    logic [3:0] lv;

    drive(1'b1, 2'b01, 1'b0, 4'h0);
    #2;

    // Reset, 1 Hz: first tick 4 cycles after release, digit 2 at cycle 8.
    do_reset(2'b01);
    first_tick = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 2'b01);
      if (bus.tick && first_tick == 0) first_tick = i;
      if (i == 8) check("digit_at_8", 32'(bus.digit), 32'd2);
    end
    check("first_tick_cycle", 32'(first_tick), 32'd4);

    // Full speed walk through all 16 values.
    do_reset(2'b00);
    ticks = 0;
    wraps = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 2'b00);
      if (bus.tick) ticks++;
      if (bus.wrap) begin
        wraps++;
        check("wrap_digit", 32'(bus.digit), 32'd0);
      end
    end
    check("walk_ticks", 32'(ticks), 32'd16);
    check("walk_wraps", 32'(wraps), 32'd1);
    check("walk_digit", 32'(bus.digit), 32'd0);

    // Quarter speed with a 10-cycle enable gap mid-period.
    do_reset(2'b11);
    enabled = 0;
    ticks   = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 2'b11);
      enabled++;
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 2'b11);
      if (bus.tick) ticks++;
    end
    check("gap_ticks", 32'(ticks), 32'd0);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step(1'b1, 2'b11);
      enabled++;
      got = bus.tick;
    end
    check("gap_tick_seen", 32'(got), 32'd1);
    check("gap_enabled_cycles", 32'(enabled), 32'd16);

    // Speed change 01 -> 10 with the divider at 1.
    do_reset(2'b01);
    step(1'b1, 2'b01);
    step(1'b1, 2'b01);
    step(1'b1, 2'b10);
    check("spd_chg_tick", 32'(bus.tick), 32'd0);
    gap = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step(1'b1, 2'b10);
      gap++;
      got = bus.tick;
    end
    check("spd_chg_gap", 32'(gap), 32'd8);

    // Mid-period asynchronous reset at digit 9.
    do_reset(2'b00);
    for (int i = 0; i < 9; i++) step(1'b1, 2'b00);
    check("digit_9", 32'(bus.digit), 32'd9);
    step(1'b1, 2'b01);
    step(1'b1, 2'b01);
    do_reset(2'b01);

`ifdef HEX_COUNTER_LOAD_EN
    // Load wins over a same-cycle advance, then counting resumes to wrap.
    do_reset(2'b00);
    for (int i = 0; i < 3; i++) step(1'b1, 2'b00);
    step(1'b1, 2'b00, 1'b1, 4'hE);
    check("load_digit", 32'(bus.digit), 32'hE);
    check("load_tick",  32'(bus.tick),  32'd0);
    step(1'b1, 2'b00);
    check("after_load_f", 32'(bus.digit), 32'hF);
    step(1'b1, 2'b00);
    check("after_load_wrap", 32'(bus.wrap), 32'd1);
    step(1'b0, 2'b01, 1'b1, 4'h5);
    check("load_disabled", 32'(bus.digit), 32'h5);
`endif

    // Randomized stimulus against the model.
    spd = 2'($urandom_range(0, 3));
    do_reset(spd);
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) spd = 2'($urandom_range(0, 3));
      ld = 1'b0;
      lv = 4'($urandom_range(0, 15));
`ifdef HEX_COUNTER_LOAD_EN
      ld = ($urandom_range(0, 24) == 0);
`endif
      if ($urandom_range(0, 299) == 0) do_reset(spd);
      else step(en, spd, ld, ld ? lv : 4'h0);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/hex_counter.md
HEX_COUNTER -- requirements
Module: hex_counter

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, the clock cycles per 1 Hz tick.
REQ-002 SHALL have parameter DIV_W, default 28, the divider width; it must be wide enough for 4*CLK_HZ-1.
REQ-003 clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 resetn  input  1  reset, asynchronous and active-low.
REQ-005 enable  input  1  allows the divider and the counter to advance when high.
REQ-006 speed  input  2  tick rate: 00 = every cycle, 01 = 1 Hz, 10 = 0.5 Hz, 11 = 0.25 Hz.
REQ-007 load  input  1  parallel load strobe; present only with HEX_COUNTER_LOAD_EN.
REQ-008 load_val  input  4  value to load; present only with HEX_COUNTER_LOAD_EN.
REQ-009 digit  output  4  current count, wired directly to the downstream 7-segment decoder's 4-bit input.
REQ-010 tick  output  1  one-cycle pulse, registered, marking each digit advance.
REQ-011 wrap  output  1  one-cycle pulse, registered, marking the F->0 roll-over.

Function
REQ-012 Divider period P SHALL be 1, CLK_HZ, 2*CLK_HZ or 4*CLK_HZ for speed 00/01/10/11.
REQ-013 The divider SHALL down-count from P-1 to 0 while enable=1, hold while enable=0, and reload P-1 on the cycle after reaching 0.
REQ-014 An internal advance SHALL occur in a cycle where enable=1 and the divider equals 0; for speed 00 this is every enabled cycle.
REQ-015 On an advance, digit SHALL become digit+1 mod 16 on the next edge, with tick=1 on that same edge.
REQ-016 When an advance moves digit from F to 0, wrap SHALL be 1 in the same cycle as tick; otherwise wrap SHALL be 0.
REQ-017 tick and wrap SHALL be 0 in every cycle with no advance; neither is ever high for more than one consecutive cycle unless speed=00.
REQ-018 A change of speed (sampled vs. previous cycle) SHALL reload the divider with the new P-1, and no advance occurs that cycle.
REQ-019 Latency from enable rising to first tick SHALL be the remaining divider count + 1 cycle; enable falling SHALL suppress ticks from the next edge.
REQ-020 Reset mid-count SHALL abandon the divider value; counting restarts from the full period after release.

Reset
REQ-021 While resetn=0: digit=0, tick=0, wrap=0, divider=P-1 for the current speed, speed history=current speed.
REQ-022 The first advance after release SHALL occur no sooner than P cycles after release with enable held high.

Configuration
REQ-023 With HEX_COUNTER_LOAD_EN defined: load=1 SHALL set digit=load_val on the next edge, reload the divider with P-1, and force tick=0 and wrap=0. load takes priority over an advance and over a speed change in the same cycle, and it works with enable=0.
REQ-024 Without HEX_COUNTER_LOAD_EN: the load and load_val ports SHALL be absent and digit changes only by reset or advance.

Structure
REQ-025 Package hex_counter_pkg SHALL hold the speed encoding constants (SPD_FULL, SPD_1HZ, SPD_HALF, SPD_QUARTER) and the digit width constant DIGIT_W=4.
REQ-026 Sub-module rate_divider SHALL contain the divider counter, the period selection and speed-change reload, and produce the advance strobe. hex_counter instantiates it once and owns digit, tick and wrap.

Verification (CLK_HZ=4 for simulation)
REQ-027 Reset, speed=01, enable=1 -> digit=0 during reset; first tick 4 cycles after release; digit=1, then 2 at cycle 8.
REQ-028 speed=00, enable=1 for 16 cycles from 0 -> digit walks 1..F,0; tick high every cycle; wrap high only on the cycle digit=0.
REQ-029 speed=11, enable dropped for 10 cycles mid-period -> no tick during the gap; the next tick arrives after the remaining count, for 16 enabled cycles per step in total.
REQ-030 speed switched 01->10 with divider at 1 -> no tick that cycle; the next tick arrives 8 cycles later.
REQ-031 HEX_COUNTER_LOAD_EN, load=1 with load_val=E in the same cycle as an advance -> digit=E, tick=0; the next advances give F, then 0 with wrap=1.
REQ-032 Assert resetn=0 asynchronously mid-period at digit=9 -> digit=0, tick=0 immediately, with no clock edge needed.
